// File: rtl/seq_divider_pkg.sv
// Shared CPU divider package.
//   DIV_WIDTH    : native operand width of the datapath
//   div_state_t  : divider sequencer states
//   DBZ_QUOTIENT : quotient returned on a divide by zero (all ones)
//   HI / LO      : result-half indices, also used by the Z/HI/LO registers
//                  (HI = remainder / upper half, LO = quotient / lower half)
package seq_divider_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      FIX  = 2'd3
   } div_state_t;

   localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

   localparam int HI = 1;
   localparam int LO = 0;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem    : partial remainder (always < dvs on entry)
//   quo    : shifting dividend/quotient register; MSB feeds the remainder
//   dvs    : divisor magnitude
//   rem_nx : partial remainder after this step
//   quo_nx : quo shifted left with the new quotient bit in the LSB
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_nx,
   output logic [WIDTH-1:0] quo_nx
);

   logic [WIDTH:0] trial;

   // rem < dvs keeps {rem, bit} below 2*dvs, so bit WIDTH of the
   // difference is a clean borrow flag and a non-negative result fits
   // in WIDTH bits.
   assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

   always_comb begin
      rem_nx = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_nx = {quo[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_nx = trial[WIDTH-1:0];
         quo_nx = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider feeding the Z register.
//   clk         : clock, rising edge
//   clr         : synchronous active-high reset, overrides everything
//   start       : divide request, honoured only in IDLE
//   signed_op   : 1 = two's-complement divide, 0 = unsigned
//   dividend    : numerator, captured with start
//   divisor     : denominator, captured with start
//   busy        : operation in progress
//   done        : one-cycle completion pulse
//   div_by_zero : divisor was zero; valid from done until next start
//   result      : {remainder, quotient}, held until the next done
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);

   // Extend the shared all-ones pattern to WIDTH bits.
   localparam logic [WIDTH-1:0] DBZ_Q =
      WIDTH'({((WIDTH + DIV_WIDTH - 1) / DIV_WIDTH){DBZ_QUOTIENT}});

   div_state_t state, state_n;

   logic [WIDTH-1:0]        dvd_raw, dvs_raw;
   logic                    sgn;
   logic [WIDTH-1:0]        dvs_mag, rem_acc, quo_sh;
   logic [WIDTH-1:0]        rem_nx, quo_nx;
   logic [CW-1:0]           count;
   logic                    q_neg, r_neg, dbz_pend;
   logic [1:0][WIDTH-1:0]   res_q, res_d;

   logic                    a_neg, b_neg;
   logic [WIDTH-1:0]        dvd_mag, dvs_mag_d, quo_fix, rem_fix;

   // ---------------- state register / next state ----------------
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = PREP;
         PREP:    state_n = (dvs_raw == '0) ? FIX : ITER;
         ITER:    if (count == CW'(WIDTH - 1)) state_n = FIX;
         FIX:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // ---------------- operand conditioning ----------------
   assign a_neg     = sgn & dvd_raw[WIDTH-1];
   assign b_neg     = sgn & dvs_raw[WIDTH-1];
   assign dvd_mag   = a_neg ? -dvd_raw : dvd_raw;
   assign dvs_mag_d = b_neg ? -dvs_raw : dvs_raw;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem    (rem_acc),
      .quo    (quo_sh),
      .dvs    (dvs_mag),
      .rem_nx (rem_nx),
      .quo_nx (quo_nx)
   );

   // Sign fix-up: quotient truncates toward zero, remainder follows the
   // dividend. The most-negative / -1 case wraps to itself naturally.
   assign quo_fix = q_neg ? -quo_sh  : quo_sh;
   assign rem_fix = r_neg ? -rem_acc : rem_acc;

   always_comb begin
      res_d[HI] = dbz_pend ? dvd_raw : rem_fix;
      res_d[LO] = dbz_pend ? DBZ_Q   : quo_fix;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (clr) begin
         dvd_raw     <= '0;
         dvs_raw     <= '0;
         sgn         <= 1'b0;
         dvs_mag     <= '0;
         rem_acc     <= '0;
         quo_sh      <= '0;
         count       <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         dbz_pend    <= 1'b0;
         div_by_zero <= 1'b0;
         done        <= 1'b0;
         res_q       <= '0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_raw     <= dividend;
                  dvs_raw     <= divisor;
                  sgn         <= signed_op;
                  div_by_zero <= 1'b0;
                  dbz_pend    <= 1'b0;
               end
            end
            PREP: begin
               dvs_mag  <= dvs_mag_d;
               rem_acc  <= '0;
               quo_sh   <= dvd_mag;
               count    <= '0;
               q_neg    <= a_neg ^ b_neg;
               r_neg    <= a_neg;
               dbz_pend <= (dvs_raw == '0);
            end
            ITER: begin
               rem_acc <= rem_nx;
               quo_sh  <= quo_nx;
               count   <= count + 1'b1;
            end
            FIX: begin
               res_q       <= res_d;
               div_by_zero <= dbz_pend;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state != IDLE);
   assign result = res_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [63:0] result;

   int n_chk  = 0;
   int n_fail = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .result      (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled on the following posedge (edge 0).
   task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
      start     = 1'b1;
      signed_op = s;
      dividend  = a;
      divisor   = b;
      @(posedge clk);
      #1;
      start     = 1'b0;
      signed_op = 1'($urandom);
      dividend  = $urandom;
      divisor   = $urandom;
   endtask

   // Counts edges after edge 0 until done; optionally re-pokes start at
   // edge count 'poke' with different operands (must be ignored).
   task automatic wait_done(input string tag, input int exp_lat,
                            input logic [63:0] exp_res, input logic exp_dbz,
                            input int poke);
      int lat  = 0;
      int bbad = 0;
      forever begin
         @(negedge clk);
         if (done) break;
         if (!busy) bbad++;
         lat++;
         if (lat == poke) begin
            start     = 1'b1;
            signed_op = 1'b1;
            dividend  = 32'd1000;
            divisor   = 32'd3;
         end else begin
            start = 1'b0;
         end
         if (lat > 200) break;
      end
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " result"}, result, exp_res);
      chk({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
      chk({tag, " busy gaps"}, 64'(bbad), 64'd0);
      chk({tag, " busy at done"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int ndone;
      clr       = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset dbz", 64'(div_by_zero), 64'd0);
      chk("reset result", result, 64'd0);
      clr = 1'b0;
      @(negedge clk);

      // unsigned 100 / 7
      do_start(1'b0, 32'd100, 32'd7);
      wait_done("u100/7", 34, 64'h00000002_0000000E, 1'b0, 0);
      @(negedge clk);
      chk("done one pulse", 64'(done), 64'd0);
      chk("result held", result, 64'h00000002_0000000E);

      // signed cases
      do_start(1'b1, 32'hFFFFFF9C, 32'd7);
      wait_done("s-100/7", 34, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 0);
      do_start(1'b1, 32'd100, 32'hFFFFFFF9);
      wait_done("s100/-7", 34, 64'h00000002_FFFFFFF2, 1'b0, 0);
      do_start(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
      wait_done("s-100/-7", 34, 64'hFFFFFFFE_0000000E, 1'b0, 0);

      // divide by zero, then back-to-back valid divide in the done cycle
      do_start(1'b0, 32'h12345678, 32'd0);
      wait_done("dbz", 2, 64'h12345678_FFFFFFFF, 1'b1, 0);
      do_start(1'b0, 32'hFFFFFFFF, 32'd1);
      chk("dbz held after restart", result, 64'h12345678_FFFFFFFF);
      wait_done("uFFFFFFFF/1", 34, 64'h00000000_FFFFFFFF, 1'b0, 0);

      // signed overflow and unsigned boundary
      do_start(1'b1, 32'h80000000, 32'hFFFFFFFF);
      wait_done("s-min/-1", 34, 64'h00000000_80000000, 1'b0, 0);
      do_start(1'b0, 32'h80000000, 32'hFFFFFFFF);
      wait_done("u8000/FFFF", 34, 64'h80000000_00000000, 1'b0, 0);
      do_start(1'b0, 32'd7, 32'd100);
      wait_done("u7/100", 34, 64'h00000007_00000000, 1'b0, 0);
      do_start(1'b1, 32'hFFFFFF9C, 32'd0);
      wait_done("sdbz", 2, 64'hFFFFFF9C_FFFFFFFF, 1'b1, 0);

      // start during busy is ignored
      do_start(1'b0, 32'd100, 32'd7);
      wait_done("ignore", 34, 64'h00000002_0000000E, 1'b0, 5);

      // clr mid-operation
      @(negedge clk);
      do_start(1'b0, 32'd50, 32'd3);
      repeat (9) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr busy", 64'(busy), 64'd0);
      chk("clr done", 64'(done), 64'd0);
      chk("clr result", result, 64'd0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("no done after clr", 64'(ndone), 64'd0);
      do_start(1'b0, 32'd1000, 32'd3);
      wait_done("after clr", 34, 64'h00000001_0000014D, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
